// File: rtl/exec_proof_reporter_pkg.sv
// rtl/exec_proof_reporter_pkg.sv - shared ER/attestation types and constants
package exec_proof_reporter_pkg;

    localparam int ADDR_W        = 16;
    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_REPORT = 2'd2
    } er_state_t;

endpackage

// File: rtl/exec_proof_reporter_sat_counter.sv
// rtl/exec_proof_reporter_sat_counter.sv - saturating up-counter with sync reset
module exec_proof_reporter_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/exec_proof_reporter.sv
// rtl/exec_proof_reporter.sv - turns ER entry/exit and exec flag into proof records
module exec_proof_reporter
    import exec_proof_reporter_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              exec,
    input  logic [ADDR_W-1:0] ER_min,
    input  logic [ADDR_W-1:0] ER_max,
    input  logic              proof_ready,
    output logic              proof_valid,
    output logic              proof_exec,
    output logic [CNT_W-1:0]  proof_count,
    output logic              in_er,
    output logic              overrun
);

    er_state_t state;
    logic      entry;
    logic      complete;

    assign entry    = (pc == ER_min) && exec;
    // exec drop has priority over reaching ER_max, so a completion needs exec high
    assign complete = (state == ST_RUN) && exec && (pc == ER_max);

    exec_proof_reporter_sat_counter #(.W(CNT_W)) u_count (
        .clk   (clk),
        .reset (reset),
        .inc   (complete),
        .count (proof_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            proof_valid <= 1'b0;
            proof_exec  <= 1'b0;
            in_er       <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (entry) begin
                        state <= ST_RUN;
                        in_er <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!exec) begin
                        state       <= ST_REPORT;
                        in_er       <= 1'b0;
                        proof_valid <= 1'b1;
                        proof_exec  <= 1'b0;
                    end else if (pc == ER_max) begin
                        state       <= ST_REPORT;
                        in_er       <= 1'b0;
                        proof_valid <= 1'b1;
                        proof_exec  <= 1'b1;
                    end
                end
                ST_REPORT: begin
                    // an entry seen here is lost even if the handshake completes now
                    if (entry) begin
                        overrun <= 1'b1;
                    end
                    if (proof_ready) begin
                        state       <= ST_IDLE;
                        proof_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
